seq_check_sched: RTL and testbench

Round-robin scheduler that shares one two-symbol sequence-checker core among `N_REQ` requesters. A requester is granted exclusive use of the core for a session, streams symbols with a valid/ready handshake, and marks the final symbol. The scheduler returns a one-cycle done pulse carrying the match verdict and the requester ID. It sits between the per-channel event sources and the result-collection logic, and replaces per-channel checker instances.

---
 rtl/seq_check_sched_if.sv | 32 +++
 rtl/seq_check_sched.sv | 170 +++++++++++++++++
 tb/tb_seq_check_sched.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_check_sched_if.sv
// seq_check_sched_if
//   Bundles the requester-side and result-side signals of seq_check_sched.
//   master : requester/collector side (drives req, sym_valid, sym, last)
//   slave  : scheduler side (drives gnt, sym_ready, done, match,
//            timed_out, done_id)
//   Requester k places its symbol in sym[k*I_WIDTH +: I_WIDTH].
interface seq_check_sched_if #(
  parameter int N_REQ    = 4,
  parameter int I_WIDTH  = 2,
  parameter int ID_WIDTH = 2
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         sym_valid;
  logic [N_REQ*I_WIDTH-1:0] sym;
  logic [N_REQ-1:0]         last;
  logic [N_REQ-1:0]         gnt;
  logic                     sym_ready;
  logic                     done;
  logic                     match;
  logic                     timed_out;
  logic [ID_WIDTH-1:0]      done_id;

  modport master (
    output req, sym_valid, sym, last,
    input  gnt, sym_ready, done, match, timed_out, done_id
  );

  modport slave (
    input  req, sym_valid, sym, last,
    output gnt, sym_ready, done, match, timed_out, done_id
  );
endinterface

// File: rtl/seq_check_sched.sv
// seq_check_sched
//   Round-robin scheduler sharing one two-symbol sequence checker among
//   N_REQ requesters. A granted requester streams symbols (valid/ready),
//   flags the final one with last, and receives a one-cycle done pulse
//   with the verdict (match), a timeout flag and its index (done_id).
//   match is set iff symbol 0 has bit0=1 and symbol 1 has bit1=1.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : seq_check_sched_if.slave (req/sym_valid/sym/last in,
//          gnt/sym_ready/done/match/timed_out/done_id out)
// Configuration
//   SEQ_CHECK_SCHED_TIMEOUT_EN : when defined, a RUN session with TIMEOUT
//   consecutive cycles without an accepted symbol is force-ended with
//   timed_out=1. When undefined, RUN waits for last and timed_out is 0.
module seq_check_sched #(
  parameter int N_REQ    = 4,
  parameter int I_WIDTH  = 2,
  parameter int ID_WIDTH = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  seq_check_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [N_REQ-1:0]    gnt_r;
  logic [ID_WIDTH-1:0] g, ptr;
  logic [ID_WIDTH-1:0] pick, pick_hi, pick_lo;
  logic                hi_vld, lo_vld, pick_vld;
  logic                sel_valid, sel_last;
  logic [1:0]          x;
  logic                acc, fire_to;
  logic [2:0]          s, s_upd;
  logic                hit, hit_upd;
  logic                match_r, to_r;
  logic [ID_WIDTH-1:0] id_r;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        pick_lo = ID_WIDTH'(k);
        lo_vld  = 1'b1;
        if (k >= int'(ptr)) begin
          pick_hi = ID_WIDTH'(k);
          hi_vld  = 1'b1;
        end
      end
    end
    pick     = hi_vld ? pick_hi : pick_lo;
    pick_vld = lo_vld;
  end

  // Route the granted requester's inputs to the core; others are ignored.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    x         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (g == ID_WIDTH'(k)) begin
        sel_valid = bus.sym_valid[k];
        sel_last  = bus.last[k];
        x         = bus.sym[k*I_WIDTH +: 2];
      end
    end
  end

  assign acc     = (state == RUN) && sel_valid;
  assign s_upd   = {s[1] & x[1], s[0] & x[0], 1'b0};
  assign hit_upd = hit | s_upd[2];

`ifdef SEQ_CHECK_SCHED_TIMEOUT_EN
  logic [7:0] idle_cnt, idle_inc;

  assign idle_inc = idle_cnt + 8'd1;
  // An accept in the same cycle always wins over the timeout.
  assign fire_to  = (state == RUN) && !acc && (idle_inc == 8'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state == IDLE) begin
      idle_cnt <= '0;
    end else if (state == RUN) begin
      idle_cnt <= acc ? 8'd0 : idle_inc;
    end
  end
`else
  logic unused_timeout;

  assign fire_to        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.sym_ready = 1'b0;
    bus.done      = 1'b0;
    unique case (state)
      IDLE: if (pick_vld) state_next = RUN;
      RUN: begin
        bus.sym_ready = 1'b1;
        if ((acc && sel_last) || fire_to) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r   <= '0;
      g       <= '0;
      ptr     <= '0;
      s       <= 3'b001;
      hit     <= 1'b0;
      match_r <= 1'b0;
      to_r    <= 1'b0;
      id_r    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_r <= N_REQ'(1) << pick;
            g     <= pick;
            s     <= 3'b001;
            hit   <= 1'b0;
          end
        end
        RUN: begin
          if (acc) begin
            s   <= s_upd;
            hit <= hit_upd;
          end
          // Verdict is captured on exit so it includes the final symbol.
          if (state_next == DONE) begin
            gnt_r   <= '0;
            match_r <= acc ? hit_upd : hit;
            to_r    <= fire_to;
            id_r    <= g;
          end
        end
        DONE: ptr <= (g == ID_WIDTH'(N_REQ - 1)) ? '0 : g + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.match     = match_r;
  assign bus.timed_out = to_r;
  assign bus.done_id   = id_r;

endmodule

// File: tb/tb_seq_check_sched.sv
// tb_seq_check_sched
//   Self-checking bench for seq_check_sched: a session-level reference model
//   (counts accepted symbols, remembers the first two, round-robin pointer
//   as an integer) is compared against the DUT every cycle, plus directed
//   sessions with hand-computed verdicts and randomized traffic.
module tb_seq_check_sched;
  localparam int N_REQ    = 4;
  localparam int I_WIDTH  = 2;
  localparam int ID_WIDTH = 2;
  localparam int TIMEOUT  = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_check_sched_if #(.N_REQ(N_REQ), .I_WIDTH(I_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  seq_check_sched #(
    .N_REQ(N_REQ), .I_WIDTH(I_WIDTH), .ID_WIDTH(ID_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 session open, 2 result cycle.
  int   m_phase, m_g, m_ptr, m_nacc, m_idle;
  bit   m_b0, m_b1, m_found;
  bit   e_match, e_to;
  int   e_id;
  logic [1:0] mx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_g = 0;
      e_match = 0; e_to = 0; e_id = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.req != '0) begin
            m_found = 0;
            for (int i = 0; i < N_REQ; i++) begin
              if (!m_found && bus.req[(m_ptr + i) % N_REQ]) begin
                m_g = (m_ptr + i) % N_REQ;
                m_found = 1;
              end
            end
            m_nacc = 0; m_idle = 0; m_b0 = 0; m_b1 = 0;
            m_phase = 1;
          end
        end
        1: begin
          if (bus.sym_valid[m_g]) begin
            mx = bus.sym[m_g*I_WIDTH +: 2];
            if (m_nacc == 0)      m_b0 = mx[0];
            else if (m_nacc == 1) m_b1 = mx[1];
            if (m_nacc < 2) m_nacc++;
            m_idle = 0;
            if (bus.last[m_g]) begin
              e_match = (m_nacc >= 2) && m_b0 && m_b1;
              e_to = 0; e_id = m_g; m_phase = 2;
            end
          end else begin
`ifdef SEQ_CHECK_SCHED_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT) begin
              e_match = (m_nacc >= 2) && m_b0 && m_b1;
              e_to = 1; e_id = m_g; m_phase = 2;
            end
`endif
          end
        end
        default: begin
          m_ptr = (m_g + 1) % N_REQ;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt", bus.gnt, (m_phase == 1) ? (32'd1 << m_g) : 32'd0);
      chk("sym_ready", bus.sym_ready, m_phase == 1);
      chk("done", bus.done, m_phase == 2);
      if (m_phase == 2) begin
        chk("match", bus.match, e_match);
        chk("timed_out", bus.timed_out, e_to);
        chk("done_id", bus.done_id, e_id);
      end
    end
  end

  task automatic drive(input int k, input bit v, input bit l, input logic [1:0] s);
    bus.sym_valid[k] = v;
    bus.last[k] = l;
    bus.sym[k*I_WIDTH +: 2] = s;
  endtask

  task automatic wait_gnt(input int k, output bit ok);
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (bus.gnt[k]) ok = 1;
    end
    if (!ok) chk("gnt_wait", bus.gnt[k], 1);
  endtask

  // Runs one session on requester k; syms[1:0] is the first symbol.
  task automatic session(input int k, input int nsym, input logic [5:0] syms,
                         output logic m, output logic to, output logic [1:0] id);
    bit ok;
    m = 0; to = 0; id = 0;
    bus.req[k] = 1'b1;
    wait_gnt(k, ok);
    bus.req[k] = 1'b0;
    if (ok) begin
      for (int i = 0; i < nsym; i++) begin
        drive(k, 1'b1, i == nsym - 1, syms[2*i +: 2]);
        @(negedge clk);
        if (i < nsym - 1) chk("no_early_done", bus.done, 0);
      end
      drive(k, 1'b0, 1'b0, 2'b00);
      chk("done_after_last", bus.done, 1);
      m = bus.match; to = bus.timed_out; id = bus.done_id;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic m, to;
    logic [1:0] id;
    bit ok;
    int cnt;
    int rr_idx[$];
    logic [3:0] rr_g[$];
    int dcount;

    bus.req = '0; bus.sym_valid = '0; bus.last = '0; bus.sym = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ready", bus.sym_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_to", bus.timed_out, 0);
    chk("rst_id", bus.done_id, 0);
    rst = 1'b0;
    @(negedge clk);

    // Match on requester 2: 01 then 10.
    session(2, 2, 6'b00_10_01, m, to, id);
    chk("match_r2", m, 1); chk("match_r2_to", to, 0); chk("match_r2_id", id, 2);
    // Mismatch: 10 then 11.
    session(1, 2, 6'b00_11_10, m, to, id);
    chk("mismatch_r1", m, 0); chk("mismatch_r1_id", id, 1);
    // Single symbol with last.
    session(0, 1, 6'b00_00_01, m, to, id);
    chk("single_sym", m, 0); chk("single_sym_id", id, 0);
    // Third symbol leaves a match intact.
    session(3, 3, 6'b00_10_01, m, to, id);
    chk("three_sym_match", m, 1); chk("three_sym_id", id, 3);
    // Third symbol cannot create a match.
    session(3, 3, 6'b10_00_01, m, to, id);
    chk("late_sym", m, 0);

    // Isolation: requester 3 streams valid+last without a grant.
    drive(3, 1'b1, 1'b1, 2'b11);
    session(1, 2, 6'b00_10_01, m, to, id);
    chk("iso_match", m, 1); chk("iso_id", id, 1);
    drive(3, 1'b0, 1'b0, 2'b00);
    @(negedge clk);

    // Asynchronous reset mid-session.
    bus.req[0] = 1'b1;
    wait_gnt(0, ok);
    bus.req[0] = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b01);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", bus.gnt, 0);
    chk("arst_ready", bus.sym_ready, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_match", bus.match, 0);
    chk("arst_to", bus.timed_out, 0);
    chk("arst_id", bus.done_id, 0);
    drive(0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b0001;
    @(negedge clk);
    chk("post_rst_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    drive(0, 1'b1, 1'b1, 2'b01);
    @(negedge clk);
    chk("post_rst_done", bus.done, 1);
    drive(0, 1'b0, 1'b0, 2'b00);

    // Round-robin from a fresh reset (ptr = 0).
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1111; bus.sym_valid = 4'b1111; bus.last = 4'b1111;
    bus.sym = 8'b01_10_11_01;
    dcount = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        rr_idx.push_back(c);
        rr_g.push_back(bus.gnt);
      end
      if (bus.done) dcount++;
    end
    bus.req = '0; bus.sym_valid = '0; bus.last = '0;
    chk("rr_count", rr_g.size(), 5);
    chk("rr_done_count", dcount, 5);
    for (int i = 0; i < rr_g.size(); i++) begin
      chk("rr_order", rr_g[i], 32'd1 << (i % 4));
      if (i > 0) chk("rr_spacing", rr_idx[i] - rr_idx[i-1], 3);
    end
    repeat (3) @(negedge clk);

`ifdef SEQ_CHECK_SCHED_TIMEOUT_EN
    // Plain timeout.
    bus.req[0] = 1'b1;
    wait_gnt(0, ok);
    bus.req[0] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && !bus.done; c++) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_latency", cnt, 15);
    chk("to_flag", bus.timed_out, 1);
    chk("to_id", bus.done_id, 0);
    chk("to_match", bus.match, 0);
    // Accept in cycle 15 restarts the count.
    bus.req[2] = 1'b1;
    wait_gnt(2, ok);
    bus.req[2] = 1'b0;
    repeat (14) @(negedge clk);
    drive(2, 1'b1, 1'b0, 2'b01);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 2'b00);
    chk("to_accept_wins", bus.done, 0);
    cnt = 15;
    for (int c = 0; c < 40 && !bus.done; c++) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_restart_latency", cnt, 30);
    chk("to_restart_flag", bus.timed_out, 1);
    chk("to_restart_id", bus.done_id, 2);
    repeat (2) @(negedge clk);
`endif

    // Randomized traffic, with one asynchronous reset pulse.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.req       = N_REQ'($urandom);
      bus.sym_valid = N_REQ'($urandom);
      bus.last      = N_REQ'($urandom & $urandom);
      bus.sym       = (N_REQ*I_WIDTH)'($urandom);
      if (i == 200) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    bus.req = '0; bus.sym_valid = '0; bus.last = '0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
